spi_master: RTL and testbench

- SPI mode-0 master (CPOL=0, CPHA=0) that pairs with the team's SPI slave and drives the off-board RTC and peripheral buses.
- Takes a parallel word through a start/busy/done handshake.
- Generates ss, sclk and mosi from the system clock, and returns the word shifted in on miso.
- Single chip select, MSB first, one word per ss assertion.

---
 rtl/spi_master_if.sv | 27 ++
 rtl/spi_master.sv | 135 +++++++++++++
 tb/tb_spi_master.sv | 362 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_if.sv
// Bus between the SPI mode-0 master and its user: parallel word handshake plus the SPI pins.
// Handshake: start is taken only on a clk edge where busy=0; busy then stays high until the
// cycle done pulses for exactly one cycle, and rx_data is valid from that cycle until the next done.
interface spi_master_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] tx_data;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] rx_data;
  logic             ss;
  logic             sclk;
  logic             mosi;
  logic             miso;
  logic [2:0]       dbg_state;

  modport master (
    input  start, tx_data, miso,
    output busy, done, rx_data, ss, sclk, mosi, dbg_state
  );

  modport slave (
    output start, tx_data, miso,
    input  busy, done, rx_data, ss, sclk, mosi, dbg_state
  );
endinterface

// File: rtl/spi_master.sv
// SPI mode-0 master (CPOL=0, CPHA=0), MSB first, one WIDTH-bit word per ss assertion.
// Every SPI pin and handshake output comes straight from a flop.
module spi_master #(
  parameter int WIDTH  = 8,
  parameter int CLKDIV = 4
) (
  input  logic         clk,
  input  logic         rst,
  spi_master_if.master bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int DW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    HIGH  = 3'd2,
    LOW   = 3'd3,
    HOLD  = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [DW-1:0]    div_q, div_d;
  logic [CW-1:0]    bit_q, bit_d;
  logic [WIDTH-1:0] tx_sr_q, tx_sr_d;
  logic [WIDTH-1:0] rx_sr_q, rx_sr_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic             ss_q, ss_d;
  logic             sclk_q, sclk_d;
  logic             mosi_q, mosi_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             phase_end;

  assign phase_end = (div_q == DW'(CLKDIV - 1));

  always_comb begin
    state_d   = state_q;
    div_d     = phase_end ? '0 : div_q + 1'b1;
    bit_d     = bit_q;
    tx_sr_d   = tx_sr_q;
    rx_sr_d   = rx_sr_q;
    rx_data_d = rx_data_q;
    ss_d      = ss_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        // The divider only runs while a transfer is in flight.
        div_d = '0;
        if (bus.start) begin
          tx_sr_d = bus.tx_data;
          ss_d    = 1'b0;
          mosi_d  = bus.tx_data[WIDTH-1];
          busy_d  = 1'b1;
          bit_d   = '0;
          state_d = SETUP;
        end
      end
      SETUP, LOW: begin
        if (phase_end) begin
          sclk_d  = 1'b1;
          rx_sr_d = {rx_sr_q[WIDTH-2:0], bus.miso};
          bit_d   = bit_q + 1'b1;
          state_d = HIGH;
        end
      end
      HIGH: begin
        if (phase_end) begin
          sclk_d = 1'b0;
          if (bit_q < CW'(WIDTH)) begin
            // Next bit goes out on the falling edge so the slave samples it stable on the rise.
            tx_sr_d = tx_sr_q << 1;
            mosi_d  = tx_sr_q[WIDTH-2];
            state_d = LOW;
          end else begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (phase_end) begin
          ss_d      = 1'b1;
          mosi_d    = 1'b0;
          rx_data_d = rx_sr_q;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          state_d   = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      div_q     <= '0;
      bit_q     <= '0;
      tx_sr_q   <= '0;
      rx_sr_q   <= '0;
      rx_data_q <= '0;
      ss_q      <= 1'b1;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      tx_sr_q   <= tx_sr_d;
      rx_sr_q   <= rx_sr_d;
      rx_data_q <= rx_data_d;
      ss_q      <= ss_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.ss        = ss_q;
  assign bus.sclk      = sclk_q;
  assign bus.mosi      = mosi_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.rx_data   = rx_data_q;
  assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master (WIDTH=8, CLKDIV=4): edge-accurate pin checks plus a received-word scoreboard.
module tb_spi_master;
  localparam int WIDTH     = 8;
  localparam int CLKDIV    = 4;
  localparam int DONE_EDGE = (2 * WIDTH + 1) * CLKDIV;

  logic clk;
  logic rst;
  spi_master_if #(.WIDTH(WIDTH)) bus ();

  spi_master #(.WIDTH(WIDTH), .CLKDIV(CLKDIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] exp_q[$];

  // miso source: 0 = loopback from mosi, 1 = constant, 2 = slave model
  int   miso_mode = 0;
  logic miso_const = 1'b0;
  logic slv_miso;
  assign bus.miso = (miso_mode == 0) ? bus.mosi : ((miso_mode == 1) ? miso_const : slv_miso);

  // Idealised mode-0 slave: loads its word on ss fall, samples on sclk rise, shifts on sclk fall.
  logic [7:0] slv_preload = 8'h00;
  logic [7:0] slv_tx_sr = 8'h00;
  logic [7:0] slv_rx_sr = 8'h00;
  logic [7:0] slv_rx_buffer = 8'h00;
  int         slv_bits = 0;
  int         slv_dv_cnt = 0;
  logic       slv_ss_prev = 1'b1;
  logic       slv_sclk_prev = 1'b0;
  assign slv_miso = slv_tx_sr[7];

  always @(bus.ss, bus.sclk) begin
    if (bus.ss === 1'b0 && slv_ss_prev === 1'b1) begin
      slv_tx_sr = slv_preload;
      slv_bits  = 0;
    end else if (bus.ss === 1'b0 && bus.sclk === 1'b1 && slv_sclk_prev === 1'b0) begin
      slv_rx_sr = {slv_rx_sr[6:0], bus.mosi};
      slv_bits++;
      if (slv_bits == 8) begin
        slv_rx_buffer = slv_rx_sr;
        slv_dv_cnt++;
      end
    end else if (bus.ss === 1'b0 && bus.sclk === 1'b0 && slv_sclk_prev === 1'b1) begin
      slv_tx_sr = {slv_tx_sr[6:0], 1'b0};
    end
    slv_ss_prev   = bus.ss;
    slv_sclk_prev = bus.sclk;
  end

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver + pin monitor for one transfer; edge 0 is the edge that accepts start.
  task automatic run_xfer(input logic [7:0] tx, input int pulse_at,
                          output int done_edge, output int done_cnt, output int rises,
                          output int first_rise, output logic [7:0] mosi_word,
                          output int ss_bad, output int mosi_ones,
                          output logic [7:0] rx_got, output logic busy_end);
    logic prev_sclk;
    @(negedge clk);
    bus.tx_data = tx;
    bus.start   = 1'b1;
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
    done_edge  = -1;
    done_cnt   = 0;
    rises      = 0;
    first_rise = -1;
    mosi_word  = 8'h00;
    ss_bad     = 0;
    mosi_ones  = 0;
    rx_got     = 8'h00;
    prev_sclk  = 1'b0;
    for (int e = 1; e <= 90; e++) begin
      if (e == pulse_at) bus.start = 1'b1;
      @(posedge clk);
      #1;
      if (e == pulse_at) bus.start = 1'b0;
      if (bus.sclk === 1'b1 && prev_sclk === 1'b0) begin
        rises++;
        if (first_rise < 0) first_rise = e;
        mosi_word = {mosi_word[6:0], bus.mosi};
      end
      prev_sclk = bus.sclk;
      if (bus.mosi === 1'b1) mosi_ones++;
      if (e < DONE_EDGE && bus.ss !== 1'b0) ss_bad++;
      if (e == DONE_EDGE && bus.ss !== 1'b1) ss_bad++;
      if (bus.done === 1'b1) begin
        done_cnt++;
        if (done_edge < 0) begin
          done_edge = e;
          rx_got    = bus.rx_data;
        end
      end
    end
    busy_end = bus.busy;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.tx_data = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.ss !== 1'b1 || bus.sclk !== 1'b0 || bus.mosi !== 1'b0) begin
      errors++;
      $display("FAIL reset_pins ss=%b sclk=%b mosi=%b expected 1 0 0", bus.ss, bus.sclk, bus.mosi);
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.rx_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_handshake busy=%b done=%b rx=%h expected 0 0 00", bus.busy, bus.done, bus.rx_data);
    end
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.ss !== 1'b1 || bus.busy !== 1'b0 || bus.sclk !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle ss=%b busy=%b sclk=%b expected 1 0 0", bus.ss, bus.busy, bus.sclk);
    end
  endtask

  task automatic check_word(input string name, input logic [7:0] got);
    logic [7:0] exp;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s_scoreboard got %h but no expected word queued", name, got);
    end else begin
      exp = exp_q.pop_front();
      if (got !== exp) begin
        errors++;
        $display("FAIL %s_rx got %h expected %h", name, got, exp);
      end
    end
  endtask

  task automatic test_loopback();
    int de, dc, r, fr, sb, mo;
    logic [7:0] mw, rx;
    logic be;
    miso_mode = 0;
    exp_q.push_back(8'hA5);
    run_xfer(8'hA5, 0, de, dc, r, fr, mw, sb, mo, rx, be);
    checks++;
    if (sb != 0) begin errors++; $display("FAIL loop_ss_window bad_cycles=%0d expected 0", sb); end
    checks++;
    if (r != 8 || fr != CLKDIV) begin
      errors++; $display("FAIL loop_sclk rises=%0d first=%0d expected 8 %0d", r, fr, CLKDIV);
    end
    checks++;
    if (mw !== 8'hA5) begin errors++; $display("FAIL loop_mosi got %h expected a5", mw); end
    checks++;
    if (de != DONE_EDGE || dc != 1) begin
      errors++; $display("FAIL loop_done edge=%0d count=%0d expected %0d 1", de, dc, DONE_EDGE);
    end
    check_word("loop", rx);
    checks++;
    if (be !== 1'b0) begin errors++; $display("FAIL loop_busy_after got %b expected 0", be); end
  endtask

  task automatic test_miso_high();
    int de, dc, r, fr, sb, mo;
    logic [7:0] mw, rx;
    logic be;
    miso_mode  = 1;
    miso_const = 1'b1;
    exp_q.push_back(8'hFF);
    run_xfer(8'h00, 0, de, dc, r, fr, mw, sb, mo, rx, be);
    checks++;
    if (mo != 0) begin errors++; $display("FAIL ones_mosi_high_cycles got %0d expected 0", mo); end
    checks++;
    if (r != 8) begin errors++; $display("FAIL ones_rises got %0d expected 8", r); end
    check_word("ones", rx);
    miso_mode = 0;
  endtask

  task automatic test_back_to_back();
    int done_cnt, bits, nw, ss_high;
    int done_edges[2];
    logic [7:0] rx_words[2];
    logic [7:0] mosi_words[2];
    logic [7:0] acc;
    logic prev_sclk;
    miso_mode = 0;
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'hC3);
    done_cnt = 0; bits = 0; nw = 0; ss_high = 0; acc = 8'h00; prev_sclk = 1'b0;
    done_edges[0] = -1; done_edges[1] = -1;
    rx_words[0] = 8'h00; rx_words[1] = 8'h00;
    mosi_words[0] = 8'h00; mosi_words[1] = 8'h00;
    @(negedge clk);
    bus.tx_data = 8'h3C;
    bus.start   = 1'b1;
    @(posedge clk);
    #1;
    bus.tx_data = 8'hC3;
    for (int e = 1; e <= 160; e++) begin
      @(posedge clk);
      #1;
      if (e == 70) bus.start = 1'b0;
      if (e == 90) bus.tx_data = 8'hFF;
      if (bus.sclk === 1'b1 && prev_sclk === 1'b0) begin
        acc = {acc[6:0], bus.mosi};
        bits++;
        if (bits == 8) begin
          if (nw < 2) mosi_words[nw] = acc;
          nw++;
          bits = 0;
        end
      end
      prev_sclk = bus.sclk;
      if (bus.done === 1'b1) begin
        if (done_cnt < 2) begin
          done_edges[done_cnt] = e;
          rx_words[done_cnt]   = bus.rx_data;
        end
        done_cnt++;
      end
      if (done_cnt == 1 && bus.ss === 1'b1) ss_high++;
    end
    checks++;
    if (done_cnt != 2 || done_edges[0] != DONE_EDGE || done_edges[1] != 2 * DONE_EDGE + 1) begin
      errors++;
      $display("FAIL b2b_done count=%0d edges=%0d,%0d expected 2 %0d,%0d",
               done_cnt, done_edges[0], done_edges[1], DONE_EDGE, 2 * DONE_EDGE + 1);
    end
    checks++;
    if (ss_high != 1) begin errors++; $display("FAIL b2b_ss_gap got %0d cycles expected 1", ss_high); end
    checks++;
    if (nw != 2 || mosi_words[0] !== 8'h3C || mosi_words[1] !== 8'hC3) begin
      errors++;
      $display("FAIL b2b_mosi words=%0d got %h %h expected 3c c3", nw, mosi_words[0], mosi_words[1]);
    end
    check_word("b2b_first", rx_words[0]);
    check_word("b2b_second", rx_words[1]);
  endtask

  task automatic test_start_while_busy();
    int de, dc, r, fr, sb, mo;
    logic [7:0] mw, rx;
    logic be;
    miso_mode = 0;
    exp_q.push_back(8'h5E);
    run_xfer(8'h5E, 20, de, dc, r, fr, mw, sb, mo, rx, be);
    checks++;
    if (dc != 1 || r != 8) begin
      errors++; $display("FAIL busy_ignore done=%0d rises=%0d expected 1 8", dc, r);
    end
    check_word("busy_ignore", rx);
    checks++;
    if (be !== 1'b0) begin errors++; $display("FAIL busy_ignore_idle busy=%b expected 0", be); end
  endtask

  task automatic test_mid_reset();
    int de, dc, r, fr, sb, mo, late_done;
    logic [7:0] mw, rx;
    logic be;
    miso_mode = 0;
    @(negedge clk);
    bus.tx_data = 8'h69;
    bus.start   = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (29) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (bus.ss !== 1'b1 || bus.sclk !== 1'b0 || bus.mosi !== 1'b0) begin
      errors++; $display("FAIL midrst_pins ss=%b sclk=%b mosi=%b expected 1 0 0", bus.ss, bus.sclk, bus.mosi);
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.rx_data !== 8'h00) begin
      errors++;
      $display("FAIL midrst_handshake busy=%b done=%b rx=%h expected 0 0 00", bus.busy, bus.done, bus.rx_data);
    end
    late_done = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1 || bus.ss !== 1'b1) late_done++;
    end
    checks++;
    if (late_done != 0) begin errors++; $display("FAIL midrst_quiet got %0d active cycles expected 0", late_done); end
    exp_q.push_back(8'h81);
    run_xfer(8'h81, 0, de, dc, r, fr, mw, sb, mo, rx, be);
    checks++;
    if (de != DONE_EDGE || mw !== 8'h81) begin
      errors++; $display("FAIL midrst_fresh done_edge=%0d mosi=%h expected %0d 81", de, mw, DONE_EDGE);
    end
    check_word("midrst_fresh", rx);
  endtask

  task automatic test_slave_pair();
    int de, dc, r, fr, sb, mo;
    logic [7:0] mw, rx;
    logic be;
    miso_mode   = 2;
    slv_preload = 8'h5A;
    slv_dv_cnt  = 0;
    exp_q.push_back(8'h5A);
    run_xfer(8'h96, 0, de, dc, r, fr, mw, sb, mo, rx, be);
    check_word("pair_master", rx);
    checks++;
    if (slv_rx_buffer !== 8'h96 || slv_dv_cnt != 1) begin
      errors++;
      $display("FAIL pair_slave buffer=%h dv=%0d expected 96 1", slv_rx_buffer, slv_dv_cnt);
    end
    miso_mode = 0;
  endtask

  task automatic test_random();
    int de, dc, r, fr, sb, mo;
    logic [7:0] mw, rx, tx;
    logic be;
    miso_mode = 0;
    for (int i = 0; i < 4; i++) begin
      tx = 8'($urandom_range(0, 255));
      exp_q.push_back(tx);
      run_xfer(tx, 0, de, dc, r, fr, mw, sb, mo, rx, be);
      checks++;
      if (mw !== tx || dc != 1) begin
        errors++; $display("FAIL rand_mosi got %h done=%0d expected %h 1", mw, dc, tx);
      end
      check_word("rand", rx);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.tx_data = '0;
    test_reset();
    test_loopback();
    test_miso_high();
    test_back_to_back();
    test_start_while_busy();
    test_mid_reset();
    test_slave_pair();
    test_random();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_leftover got %0d words expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
